grant_mux_stage: RTL and testbench

- Downstream consumer of the round-robin arbiter (`arbiter`, registered one-hot grant, 1-cycle req->grant latency).
- Buffers one payload per requestor and drives the arbiter's req vector from occupied slots.
- Consumes the returned one-hot grant and forwards the granted payload plus its source index on a valid/ready output port.
- Sits between the N producer ports and the single shared downstream consumer (e.g. the memory/crossbar port).

---
 rtl/grant_mux_pkg.sv | 31 +++
 rtl/grant_mux_stage_if.sv | 30 +++
 rtl/grant_mux_slot.sv | 45 ++++
 rtl/grant_mux_stage.sv | 138 +++++++++++++
 tb/tb_grant_mux_stage.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grant_mux_pkg.sv
// Shared types and helpers for the grant_mux_stage slice: FSM state encoding
// and one-hot grant decoding used by the top-level controller.
package grant_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        GNT   = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Grant vectors are zero-extended to this width before decoding, so the
    // helpers serve any N up to MAX_N without per-instance specialisation.
    localparam int MAX_N     = 32;
    localparam int MAX_IDX_W = 5;

    function automatic logic is_onehot(input logic [MAX_N-1:0] v);
        return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
    endfunction

    // Only meaningful for a one-hot input; callers qualify with is_onehot.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] v);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/grant_mux_stage_if.sv
// Bus bundle for grant_mux_stage: producer-side payload ports, the req/grant
// pair shared with the round-robin arbiter, and the downstream valid/ready port.
// The slave modport is the stage itself; master is whatever drives it.
interface grant_mux_stage_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_src;
    logic             out_ready;
    logic             err;

    modport slave (
        input  in_valid, in_data, grant, out_ready,
        output in_ready, req, out_valid, out_data, out_src, err
    );

    modport master (
        output in_valid, in_data, grant, out_ready,
        input  in_ready, req, out_valid, out_data, out_src, err
    );
endinterface

// File: rtl/grant_mux_slot.sv
// One-entry hold buffer for a single producer port. Accepts a payload while
// empty and releases it on a clear strobe from the controller. The controller
// only clears an occupied slot, so accept and clear never meet on one slot.
module grant_mux_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         clr,
    output logic         in_ready,
    output logic         vld,
    output logic [W-1:0] data
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    // Next-state of the slot: fill when empty, empty on clear.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (in_valid && !vld_q) begin
            vld_d  = 1'b1;
            data_d = in_data;
        end else if (clr) begin
            vld_d  = 1'b0;
        end
    end

    // Occupancy flag; reset empties the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
    end

    // Payload storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign in_ready = !vld_q;
    assign vld      = vld_q;
    assign data     = data_q;
endmodule

// File: rtl/grant_mux_stage.sv
// grant_mux_stage: buffers one payload per requestor, requests the shared
// downstream port from a round-robin arbiter (registered one-hot grant,
// 1-cycle latency) and forwards the granted payload with its source index.
// Controller cycle: IDLE -> REQ (1 cycle) -> GNT (1 cycle) -> DRAIN.
// Optional macro GRANT_MUX_CHECK_EN enables the sticky grant-protocol error
// flag; without it err is tied low and an invalid grant only retries REQ.
// N and W must match the parameters of the connected grant_mux_stage_if.
module grant_mux_stage #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic               clk,
    input  logic               rst,
    grant_mux_stage_if.slave   bus
);
    import grant_mux_pkg::*;

    localparam int IDX_W = $clog2(N);

    logic [N-1:0]     hold_vld;
    logic [N-1:0]     slot_rdy;
    logic [N-1:0]     clr;
    logic [W-1:0]     hold_data [N];
    logic [N-1:0]     accept;
    logic [N-1:0]     req_o;
    logic             gnt_ok;
    logic [IDX_W-1:0] gnt_idx;

    state_e           state_q, state_d;
    logic [N-1:0]     req_q, req_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDX_W-1:0] out_src_q, out_src_d;

    for (genvar i = 0; i < N; i++) begin : g_slot
        grant_mux_slot #(.W(W)) u_slot (
            .clk      (clk),
            .rst      (rst),
            .in_valid (bus.in_valid[i]),
            .in_data  (bus.in_data[i*W +: W]),
            .clr      (clr[i]),
            .in_ready (slot_rdy[i]),
            .vld      (hold_vld[i]),
            .data     (hold_data[i])
        );
    end

    // A grant is usable only if it is one-hot and names a port from the snapshot.
    always_comb begin
        accept  = bus.in_valid & slot_rdy;
        gnt_ok  = is_onehot(MAX_N'(bus.grant)) && ((bus.grant & req_q) != '0);
        gnt_idx = IDX_W'(onehot_to_idx(MAX_N'(bus.grant)));
    end

    // Controller next-state, request drive and output-register loading.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        clr         = '0;
        req_o       = '0;
        case (state_q)
            IDLE: begin
                if (|hold_vld) state_d = REQ;
            end
            REQ: begin
                req_o   = hold_vld;
                req_d   = hold_vld;
                state_d = GNT;
            end
            GNT: begin
                if (gnt_ok) begin
                    out_valid_d = 1'b1;
                    out_data_d  = hold_data[gnt_idx];
                    out_src_d   = gnt_idx;
                    clr         = bus.grant;
                    state_d     = DRAIN;
                end else begin
                    state_d     = REQ;
                end
            end
            DRAIN: begin
                // A slot filling on this very edge still counts as pending work.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = (|(hold_vld | accept)) ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller and output registers; reset discards any in-flight payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

`ifdef GRANT_MUX_CHECK_EN
    logic err_q, err_d;

    // Sticky protocol error: bad grant in GNT, or any grant outside GNT.
    always_comb begin
        err_d = err_q;
        if (state_q == GNT && !gnt_ok)         err_d = 1'b1;
        if (state_q != GNT && bus.grant != '0) err_d = 1'b1;
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = slot_rdy;
    assign bus.req       = req_o;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_grant_mux_stage.sv
// Testbench for grant_mux_stage with a behavioural round-robin arbiter
// (registered one-hot grant, pointer 0 after reset) and a payload scoreboard.
module tb_grant_mux_stage;
    localparam int N = 4;
    localparam int W = 32;
`ifdef GRANT_MUX_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct {
        logic [1:0]   src;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic         force_en;
    logic [N-1:0] force_val;
    logic [N-1:0] arb_gnt;
    int           arb_ptr;
    int           arb_pick;
    int           n_chk = 0;
    int           n_fail = 0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    grant_mux_stage_if #(.N(N), .W(W)) bus ();

    grant_mux_stage #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Round-robin arbiter model, with an override to inject arbitrary grants.
    function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always_comb arb_pick = rr_pick(bus.req, arb_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_gnt <= '0;
            arb_ptr <= 0;
        end else if (force_en) begin
            arb_gnt <= force_val;
        end else if (arb_pick >= 0) begin
            arb_gnt <= N'(1) << arb_pick;
            arb_ptr <= (arb_pick + 1) % N;
        end else begin
            arb_gnt <= '0;
        end
    end

    assign bus.grant = arb_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_check();
        exp_t e;
        n_chk++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected observed=src %0d data %0h expected=no output",
                   bus.out_src, bus.out_data);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_src", 64'(bus.out_src), 64'(e.src));
            chk("sb_data", 64'(bus.out_data), 64'(e.data));
        end
    endtask

    // Output handshakes complete at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1)
            mon_check();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        force_en      = 1'b0;
        force_val     = '0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_req", 64'(bus.req), 64'(0));
        chk("rst_out_data", 64'(bus.out_data), 64'(0));
        chk("rst_out_src", 64'(bus.out_src), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        rst = 1'b0;
        chk("rst_in_ready", 64'(bus.in_ready), 64'hF);

        // Single payload on port 2: latency 3 from acceptance.
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0100;
        bus.in_data[2*W +: W] = 32'hDEADBEEF;
        sb.push_back('{2'd2, 32'hDEADBEEF});
        step();
        bus.in_valid = '0;
        chk("t1_in_ready_a", 64'(bus.in_ready), 64'hB);
        chk("t1_valid_a", 64'(bus.out_valid), 64'(0));
        step();
        chk("t1_req", 64'(bus.req), 64'h4);
        chk("t1_in_ready_b", 64'(bus.in_ready), 64'hB);
        step();
        chk("t1_req_gnt", 64'(bus.req), 64'(0));
        chk("t1_valid_b", 64'(bus.out_valid), 64'(0));
        step();
        chk("t1_valid", 64'(bus.out_valid), 64'(1));
        chk("t1_data", 64'(bus.out_data), 64'hDEADBEEF);
        chk("t1_src", 64'(bus.out_src), 64'(2));
        chk("t1_in_ready_c", 64'(bus.in_ready), 64'hF);
        step();
        chk("t1_valid_done", 64'(bus.out_valid), 64'(0));
        step();
        chk("t1_sb_empty", 64'(sb.size()), 64'(0));

        // All four ports at once: order 0..3, one payload every 3 cycles.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int k = 0; k < N; k++) sb.push_back('{2'(k), 32'hA0 + 32'(k)});
        step();
        bus.in_valid = '0;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("t2_valid", 64'(bus.out_valid), 64'((c % 3) == 0));
            if ((c % 3) == 0) chk("t2_src", 64'(bus.out_src), 64'(c / 3 - 1));
        end
        step();
        chk("t2_sb_empty", 64'(sb.size()), 64'(0));

        // Backpressure in DRAIN while port 1 loads.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0001;
        bus.in_data[0 +: W] = 32'hB0;
        sb.push_back('{2'd0, 32'hB0});
        step();
        bus.in_valid = '0;
        step();
        step();
        step();
        chk("t3_valid", 64'(bus.out_valid), 64'(1));
        bus.in_valid = 4'b0010;
        bus.in_data[W +: W] = 32'hB1;
        sb.push_back('{2'd1, 32'hB1});
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0) bus.in_valid = '0;
            chk("t3_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("t3_hold_data", 64'(bus.out_data), 64'hB0);
            chk("t3_hold_src", 64'(bus.out_src), 64'(0));
            chk("t3_hold_req", 64'(bus.req), 64'(0));
        end
        chk("t3_in_ready", 64'(bus.in_ready), 64'hD);
        bus.out_ready = 1'b1;
        step();
        chk("t3_released", 64'(bus.out_valid), 64'(0));
        chk("t3_req_next", 64'(bus.req), 64'h2);
        step();
        step();
        chk("t3_valid2", 64'(bus.out_valid), 64'(1));
        chk("t3_src2", 64'(bus.out_src), 64'(1));
        chk("t3_data2", 64'(bus.out_data), 64'hB1);
        step();
        chk("t3_done", 64'(bus.out_valid), 64'(0));
        chk("t3_err", 64'(bus.err), 64'(0));
        chk("t3_sb_empty", 64'(sb.size()), 64'(0));

        // Invalid multi-hot grant in GNT, then normal recovery.
        do_reset();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0011;
        bus.in_data   = {32'h0, 32'h0, 32'hC1, 32'hC0};
        sb.push_back('{2'd0, 32'hC0});
        sb.push_back('{2'd1, 32'hC1});
        step();
        bus.in_valid = '0;
        step();
        chk("t4_req", 64'(bus.req), 64'h3);
        force_en  = 1'b1;
        force_val = 4'b0011;
        step();
        force_en = 1'b0;
        chk("t4_gnt_valid", 64'(bus.out_valid), 64'(0));
        step();
        chk("t4_no_move", 64'(bus.out_valid), 64'(0));
        chk("t4_retry_req", 64'(bus.req), 64'h3);
        chk("t4_slots_kept", 64'(bus.in_ready), 64'hC);
        chk("t4_err", 64'(bus.err), 64'(EXP_ERR));
        step();
        step();
        chk("t4_valid0", 64'(bus.out_valid), 64'(1));
        chk("t4_src0", 64'(bus.out_src), 64'(0));
        step();
        step();
        step();
        chk("t4_valid1", 64'(bus.out_valid), 64'(1));
        chk("t4_src1", 64'(bus.out_src), 64'(1));
        step();
        chk("t4_err_sticky", 64'(bus.err), 64'(EXP_ERR));
        chk("t4_sb_empty", 64'(sb.size()), 64'(0));

        // Asynchronous reset while draining with three slots still full.
        do_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        bus.in_data   = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        step();
        bus.in_valid = '0;
        step();
        step();
        step();
        chk("t5_pre_valid", 64'(bus.out_valid), 64'(1));
        chk("t5_pre_ready", 64'(bus.in_ready), 64'h1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", 64'(bus.out_valid), 64'(0));
        chk("t5_async_req", 64'(bus.req), 64'(0));
        chk("t5_async_ready", 64'(bus.in_ready), 64'hF);
        chk("t5_async_data", 64'(bus.out_data), 64'(0));
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk("t5_no_stale", 64'(bus.out_valid), 64'(0));
            chk("t5_no_req", 64'(bus.req), 64'(0));
        end
        chk("t5_sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
